// File: rtl/mem_bus_arbiter.sv
// Shares one word-wide memory bus between the fetch and data ports of the pipeline.
// Data has priority; fetch is granted after MAX_DM_STREAK consecutive data grants while it waits.
module mem_bus_arbiter #(
  parameter int MAX_DM_STREAK = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [3:0]  dm_we,
  input  logic [3:0]  dm_re,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_o,
  output logic        bus_err
);

  localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic          sel_dm;
  logic          err_q;
  logic          take_dm;
  logic          take_if;
  logic          timed_out;

  // Handshake: a requester holds req (and its address/data) high until it sees a
  // one-cycle ack; the bus side holds bus_req and all bus fields stable until bus_ack.
  always_comb begin
    state_nxt = state;
    take_dm   = 1'b0;
    take_if   = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req && !(if_req && streak == STREAK_MAX)) begin
          take_dm   = 1'b1;
          state_nxt = BUSY;
        end else if (if_req) begin
          take_if   = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          state_nxt = RESP;
        end else if (tcnt == TCNT_LAST) begin
          timed_out = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      sel_dm    <= 1'b0;
      err_q     <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      bus_we    <= 1'b0;
      bus_be    <= 4'h0;
      if_rdata  <= 32'h0;
      dm_rdata  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (take_dm) begin
        sel_dm    <= 1'b1;
        err_q     <= 1'b0;
        tcnt      <= '0;
        bus_addr  <= dm_addr;
        bus_wdata <= dm_wdata;
        bus_we    <= |dm_we;
        bus_be    <= dm_we | dm_re;
        // Streak only grows while fetch is actually waiting behind data.
        if (!if_req) begin
          streak <= '0;
        end else if (streak != STREAK_MAX) begin
          streak <= streak + SW'(1);
        end
      end else if (take_if) begin
        sel_dm    <= 1'b0;
        err_q     <= 1'b0;
        tcnt      <= '0;
        streak    <= '0;
        bus_addr  <= if_addr;
        bus_wdata <= 32'h0;
        bus_we    <= 1'b0;
        bus_be    <= 4'hF;
      end
      if (state == BUSY) begin
        tcnt <= tcnt + TW'(1);
        if (bus_ack) begin
          if (sel_dm) begin
            dm_rdata <= bus_we ? 32'h0 : bus_rdata;
          end else begin
            if_rdata <= bus_rdata;
          end
        end else if (timed_out) begin
          err_q <= 1'b1;
          if (sel_dm) begin
            dm_rdata <= 32'h0;
          end else begin
            if_rdata <= 32'h0;
          end
        end
      end
    end
  end

  assign bus_req = (state == BUSY);
  assign if_ack  = (state == RESP) && !sel_dm;
  assign dm_ack  = (state == RESP) && sel_dm;
  assign bus_err = (state == RESP) && err_q;
  assign stall_o = ~cpu_rst & ((if_req & ~if_ack) | (dm_req & ~dm_ack));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed requests, a bus responder that checks the
// issued bus fields, and an ack monitor that pops expected responses.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT = 8;

  typedef logic [68:0] vec_t;

  logic        clk = 1'b0;
  logic        cpu_rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_we;
  logic [3:0]  dm_re;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stall_o;
  logic        bus_err;

  logic        stray_ack;
  int          n_checks = 0;
  int          n_pass   = 0;

  // Expected bus transfers {we, be, addr, wdata(0 unless write)} and their responder settings.
  logic [68:0] bus_q[$];
  int          lat_q[$];
  int          len_q[$];
  logic [31:0] ret_q[$];
  // Expected acks {is_dm, err, rdata}.
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_DM_STREAK(2), .TIMEOUT(TIMEOUT)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst    (cpu_rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .dm_req     (dm_req),
    .dm_addr    (dm_addr),
    .dm_we      (dm_we),
    .dm_re      (dm_re),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .bus_req    (bus_req),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack),
    .stall_o    (stall_o),
    .bus_err    (bus_err)
  );

  task automatic check(input string name, input vec_t act, input vec_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_txn(input bit is_dm, input logic [31:0] addr, input bit we,
                            input logic [3:0] be, input logic [31:0] wdata,
                            input logic [31:0] ret, input int lat, input int blen,
                            input bit has_resp, input logic [31:0] rdata, input bit err);
    bus_q.push_back({we, be, addr, (we ? wdata : 32'h0)});
    lat_q.push_back(lat);
    len_q.push_back(blen);
    ret_q.push_back(ret);
    if (has_resp) exp_q.push_back({is_dm, err, rdata});
  endtask

  task automatic drive_req(input bit is_dm, input logic [31:0] addr, input logic [3:0] we,
                           input logic [3:0] re, input logic [31:0] wdata, input bit keep,
                           input int exp_cyc, input bit chk_stall);
    int n;
    bit got;
    if (is_dm) begin
      dm_addr = addr; dm_we = we; dm_re = re; dm_wdata = wdata; dm_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(negedge clk);
      if (is_dm ? dm_ack : if_ack) begin
        got = 1'b1;
      end else begin
        if (chk_stall) check("stall_pending", vec_t'(stall_o), vec_t'(1'b1));
        n++;
      end
    end
    check("ack_seen", vec_t'(got), vec_t'(1'b1));
    if (got && exp_cyc > 0) check("ack_latency", vec_t'(n), vec_t'(exp_cyc));
    if (got && chk_stall) check("stall_at_ack", vec_t'(stall_o), vec_t'(1'b0));
    @(posedge clk);
    #1;
    if (!keep) begin
      if (is_dm) begin
        dm_req = 1'b0; dm_we = 4'h0; dm_re = 4'h0; dm_wdata = 32'h0;
      end else begin
        if_req = 1'b0;
      end
    end
  endtask

  // Bus responder: checks fields every BUSY cycle, acks after the queued latency.
  initial begin
    int          busy_cnt;
    int          cur_lat;
    int          cur_len;
    logic [31:0] cur_ret;
    logic [68:0] cur_exp;
    bus_ack = 1'b0;
    bus_rdata = 32'hDEAD_BEEF;
    busy_cnt = 0;
    cur_lat = -1;
    cur_len = 0;
    cur_ret = 32'h0;
    cur_exp = '0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_rdata = 32'hDEAD_BEEF;
      if (bus_req) begin
        if (busy_cnt == 0) begin
          check("bus_txn_expected", vec_t'(bus_q.size() != 0), vec_t'(1'b1));
          if (bus_q.size() != 0) begin
            cur_exp = bus_q.pop_front();
            cur_lat = lat_q.pop_front();
            cur_len = len_q.pop_front();
            cur_ret = ret_q.pop_front();
          end else begin
            cur_exp = '0; cur_lat = -1; cur_len = 0; cur_ret = 32'h0;
          end
        end
        check("bus_fields", {bus_we, bus_be, bus_addr, (bus_we ? bus_wdata : 32'h0)}, cur_exp);
        if (busy_cnt == cur_lat) begin
          bus_ack = 1'b1;
          bus_rdata = cur_ret;
        end
        busy_cnt++;
      end else begin
        if (busy_cnt != 0) check("bus_req_len", vec_t'(busy_cnt), vec_t'(cur_len));
        busy_cnt = 0;
        if (stray_ack) begin
          bus_ack = 1'b1;
          bus_rdata = 32'h5A5A_5A5A;
        end
      end
    end
  end

  // Ack monitor: every ack pops one expected response.
  initial begin
    logic [33:0] r;
    forever begin
      @(negedge clk);
      check("ack_exclusive", vec_t'(if_ack & dm_ack), vec_t'(1'b0));
      check("err_only_with_ack", vec_t'(bus_err & ~(if_ack | dm_ack)), vec_t'(1'b0));
      if (if_ack || dm_ack) begin
        check("resp_expected", vec_t'(exp_q.size() != 0), vec_t'(1'b1));
        if (exp_q.size() != 0) begin
          r = exp_q.pop_front();
          check("ack_port", vec_t'(dm_ack), vec_t'(r[33]));
          check("ack_err", vec_t'(bus_err), vec_t'(r[32]));
          check("ack_rdata", vec_t'(dm_ack ? dm_rdata : if_rdata), vec_t'(r[31:0]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cpu_rst = 1'b1;
    stray_ack = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b1; dm_addr = 32'h0; dm_we = 4'h0; dm_re = 4'hF; dm_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", vec_t'(stall_o), vec_t'(1'b0));
    check("rst_bus_req", vec_t'(bus_req), vec_t'(1'b0));
    check("rst_acks", vec_t'({if_ack, dm_ack, bus_err}), vec_t'(3'b000));
    check("rst_bus_fields", {bus_we, bus_be, bus_addr, bus_wdata}, vec_t'(0));
    check("rst_rdata", vec_t'({if_rdata, dm_rdata}), vec_t'(0));
    @(posedge clk);
    #1;
    cpu_rst = 1'b0; dm_req = 1'b0; dm_re = 4'h0;
    idle(2);

    // Single load, ack in the first BUSY cycle.
    expect_txn(1'b1, 32'h100, 1'b0, 4'hF, 32'h0, 32'h1122_3344, 0, 1, 1'b1, 32'h1122_3344, 1'b0);
    drive_req(1'b1, 32'h100, 4'h0, 4'hF, 32'h0, 1'b0, 2, 1'b1);
    idle(2);

    // Byte store: rdata must read back as zero.
    expect_txn(1'b1, 32'h204, 1'b1, 4'b0010, 32'hAABB_CCDD, 32'h9988_7766, 1, 2, 1'b1, 32'h0, 1'b0);
    drive_req(1'b1, 32'h204, 4'b0010, 4'h0, 32'hAABB_CCDD, 1'b0, 3, 1'b1);
    idle(2);

    // bus_ack while idle is ignored.
    stray_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray_bus_req", vec_t'(bus_req), vec_t'(1'b0));
      check("stray_acks", vec_t'({if_ack, dm_ack, bus_err}), vec_t'(3'b000));
      check("stray_dm_rdata", vec_t'(dm_rdata), vec_t'(32'h0));
    end
    stray_ack = 1'b0;
    idle(2);

    // Contention: grant order D,D,I,D,D,I,D.
    expect_txn(1'b1, 32'h300, 1'b0, 4'hF, 32'h0, 32'hD1D1_0001, 0, 1, 1'b1, 32'hD1D1_0001, 1'b0);
    expect_txn(1'b1, 32'h304, 1'b0, 4'h3, 32'h0, 32'hD2D2_0002, 1, 2, 1'b1, 32'hD2D2_0002, 1'b0);
    expect_txn(1'b0, 32'h1000, 1'b0, 4'hF, 32'h0, 32'h2400_0001, 0, 1, 1'b1, 32'h2400_0001, 1'b0);
    expect_txn(1'b1, 32'h308, 1'b1, 4'hC, 32'h1234_5678, 32'h0BAD_F00D, 2, 3, 1'b1, 32'h0, 1'b0);
    expect_txn(1'b1, 32'h30C, 1'b0, 4'h1, 32'h0, 32'hD4D4_0004, 0, 1, 1'b1, 32'hD4D4_0004, 1'b0);
    expect_txn(1'b0, 32'h1004, 1'b0, 4'hF, 32'h0, 32'h2400_0002, 1, 2, 1'b1, 32'h2400_0002, 1'b0);
    expect_txn(1'b1, 32'h310, 1'b0, 4'hF, 32'h0, 32'hD5D5_0005, 0, 1, 1'b1, 32'hD5D5_0005, 1'b0);
    fork
      begin
        drive_req(1'b1, 32'h300, 4'h0, 4'hF, 32'h0, 1'b1, 0, 1'b0);
        drive_req(1'b1, 32'h304, 4'h0, 4'h3, 32'h0, 1'b1, 0, 1'b0);
        drive_req(1'b1, 32'h308, 4'hC, 4'h0, 32'h1234_5678, 1'b1, 0, 1'b0);
        drive_req(1'b1, 32'h30C, 4'h0, 4'h1, 32'h0, 1'b1, 0, 1'b0);
        drive_req(1'b1, 32'h310, 4'h0, 4'hF, 32'h0, 1'b0, 0, 1'b0);
      end
      begin
        drive_req(1'b0, 32'h1000, 4'h0, 4'h0, 32'h0, 1'b1, 0, 1'b0);
        drive_req(1'b0, 32'h1004, 4'h0, 4'h0, 32'h0, 1'b0, 0, 1'b0);
      end
    join
    idle(2);

    // Fetch timeout: TIMEOUT BUSY cycles, then ack with zero data and bus_err.
    expect_txn(1'b0, 32'h2000, 1'b0, 4'hF, 32'h0, 32'h0, -1, TIMEOUT, 1'b1, 32'h0, 1'b1);
    drive_req(1'b0, 32'h2000, 4'h0, 4'h0, 32'h0, 1'b0, TIMEOUT + 1, 1'b0);
    idle(2);

    // Reset on the third BUSY cycle of a load.
    expect_txn(1'b1, 32'h400, 1'b0, 4'hF, 32'h0, 32'h0, -1, 3, 1'b0, 32'h0, 1'b0);
    dm_addr = 32'h400; dm_we = 4'h0; dm_re = 4'hF; dm_wdata = 32'h0; dm_req = 1'b1;
    n = 0;
    while (!bus_req && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("rst_busy_seen", vec_t'(bus_req), vec_t'(1'b1));
    repeat (2) @(negedge clk);
    cpu_rst = 1'b1;
    @(negedge clk);
    check("midrst_bus_req", vec_t'(bus_req), vec_t'(1'b0));
    check("midrst_acks", vec_t'({if_ack, dm_ack, bus_err}), vec_t'(3'b000));
    check("midrst_stall", vec_t'(stall_o), vec_t'(1'b0));
    check("midrst_dm_rdata", vec_t'(dm_rdata), vec_t'(32'h0));
    @(posedge clk);
    #1;
    cpu_rst = 1'b0; dm_req = 1'b0; dm_re = 4'h0;
    idle(1);

    // Normal fetch after reset.
    expect_txn(1'b0, 32'h3000, 1'b0, 4'hF, 32'h0, 32'h600D_CAFE, 1, 2, 1'b1, 32'h600D_CAFE, 1'b0);
    drive_req(1'b0, 32'h3000, 4'h0, 4'h0, 32'h0, 1'b0, 3, 1'b1);
    idle(4);

    check("bus_q_drained", vec_t'(bus_q.size()), vec_t'(0));
    check("exp_q_drained", vec_t'(exp_q.size()), vec_t'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
